// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream packet source.
package stream_pkg;

  // Two-state packet FSM: waiting for a command, or streaming beats.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Width of a beat counter that must hold values 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/stream_beat_counter.sv
// Remaining-beat down-counter. The load value is clamped to MAX_LEN.
// is_last flags the beat whose remaining count is 1.
module stream_beat_counter
  import stream_pkg::*;
#(
  parameter int MAX_LEN = 256,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_len,
  input  logic             dec,
  output logic [LEN_W-1:0] cnt,
  output logic             is_last
);

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  // Next count: a load wins over a decrement; never decrement below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_len > MAX_CNT) ? MAX_CNT : load_len;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared asynchronously so an interrupted packet is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign is_last = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/stream_pkt_source.sv
// Command-driven packet generator: emits cmdLen beats of an arithmetic
// sequence (start, start+step, ...) on a valid/ready stream.
module stream_pkt_source
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 256,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] cmdStart,
  input  logic [DATA_WIDTH-1:0] cmdStep,
  input  logic [LEN_W-1:0]      cmdLen,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataOutValid,
  input  logic                  dataOutReady,
  output logic                  dataOutLast,
  output logic                  busy,
  output logic                  pktDone
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic                  pkt_done_q, pkt_done_d;

  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_last;
  logic [LEN_W-1:0]      cnt_unused;

  stream_beat_counter #(.MAX_LEN(MAX_LEN)) u_beat_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (cnt_load),
    .load_len (cmdLen),
    .dec      (cnt_dec),
    .cnt      (cnt_unused),
    .is_last  (cnt_last)
  );

  // FSM next state, accumulator update and done pulse. The data register
  // only advances on a beat handshake, so a stalled beat holds steady.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    step_d     = step_q;
    pkt_done_d = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmdValid) begin
          if (cmdLen == '0) begin
            // Empty packet: acknowledge it with a done pulse and no beats.
            pkt_done_d = 1'b1;
          end else begin
            data_d   = cmdStart;
            step_d   = cmdStep;
            cnt_load = 1'b1;
            state_d  = SEND;
          end
        end
      end
      SEND: begin
        if (dataOutReady) begin
          cnt_dec = 1'b1;
          data_d  = data_q + step_q;
          if (cnt_last) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      step_q     <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      step_q     <= step_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // All handshake outputs come straight from registered state.
  assign cmdReady     = (state_q == IDLE);
  assign busy         = (state_q == SEND);
  assign dataOutValid = (state_q == SEND);
  assign dataOutLast  = (state_q == SEND) && cnt_last;
  assign dataOut      = data_q;
  assign pktDone      = pkt_done_q;

endmodule

// File: tb/tb_stream_pkt_source.sv
// Directed bench for stream_pkt_source: inputs change after the rising
// edge, outputs are sampled on the falling edge.
module tb_stream_pkt_source;

  localparam int DW      = 32;
  localparam int MAX_LEN = 256;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] cmdStart, cmdStep;
  logic [LW-1:0] cmdLen;
  logic          cmdValid, cmdReady;
  logic [DW-1:0] dataOut;
  logic          dataOutValid, dataOutReady, dataOutLast;
  logic          busy, pktDone;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_pkt_source #(.DATA_WIDTH(DW), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmdStart     (cmdStart),
    .cmdStep      (cmdStep),
    .cmdLen       (cmdLen),
    .cmdValid     (cmdValid),
    .cmdReady     (cmdReady),
    .dataOut      (dataOut),
    .dataOutValid (dataOutValid),
    .dataOutReady (dataOutReady),
    .dataOutLast  (dataOutLast),
    .busy         (busy),
    .pktDone      (pktDone)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Offer one command for a single cycle (always accepted: bench only issues from IDLE).
  task automatic send_cmd(input logic [DW-1:0] s, input logic [DW-1:0] st, input logic [LW-1:0] l);
    @(negedge clk);
    chk("cmd_ready", 32'(cmdReady), 32'd1);
    cmdStart = s; cmdStep = st; cmdLen = l; cmdValid = 1'b1;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    cmdStart = 32'hDEAD_BEEF; cmdStep = 32'h5555_5555; cmdLen = LW'(3);
  endtask

  // Expect n beats of s + i*st; beat 0 is stalled for 'stall' cycles first.
  task automatic expect_pkt(input string tag, input logic [DW-1:0] s, input logic [DW-1:0] st,
                            input int n, input int stall);
    logic [DW-1:0] exp;
    exp = s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        for (int k = 0; k < stall; k++) begin
          dataOutReady = 1'b0;
          chk({tag, "_stall_valid"}, 32'(dataOutValid), 32'd1);
          chk({tag, "_stall_data"}, dataOut, exp);
          chk({tag, "_stall_last"}, 32'(dataOutLast), 32'(n == 1));
          @(negedge clk);
        end
      end
      dataOutReady = 1'b1;
      chk({tag, "_valid"}, 32'(dataOutValid), 32'd1);
      chk({tag, "_data"}, dataOut, exp);
      chk({tag, "_last"}, 32'(dataOutLast), 32'(i == n - 1));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_ready_busy"}, 32'(cmdReady), 32'd0);
      exp = exp + st;
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(pktDone), 32'd1);
    chk({tag, "_gap_valid"}, 32'(dataOutValid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_ready"}, 32'(cmdReady), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(pktDone), 32'd0);
    chk({tag, "_idle_valid"}, 32'(dataOutValid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmdValid = 1'b0; cmdStart = '0; cmdStep = '0; cmdLen = '0;
    dataOutReady = 1'b1;
    #12;
    chk("rst_ready", 32'(cmdReady), 32'd1);
    chk("rst_valid", 32'(dataOutValid), 32'd0);
    chk("rst_data", dataOut, 32'd0);
    chk("rst_last", 32'(dataOutLast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(pktDone), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic packet, full throughput.
    send_cmd(32'h10, 32'd4, LW'(3));
    expect_pkt("basic", 32'h10, 32'd4, 3, 0);

    // Silent wrap-around of the accumulator.
    send_cmd(32'hFFFF_FFFE, 32'd1, LW'(4));
    expect_pkt("wrap", 32'hFFFF_FFFE, 32'd1, 4, 0);

    // Backpressure on beat 0 for 5 cycles.
    send_cmd(32'h700, 32'h11, LW'(2));
    expect_pkt("stall", 32'h700, 32'h11, 2, 5);

    // Zero-length command: done pulse only.
    send_cmd(32'h1234, 32'd1, LW'(0));
    @(negedge clk);
    chk("len0_done", 32'(pktDone), 32'd1);
    chk("len0_valid", 32'(dataOutValid), 32'd0);
    chk("len0_ready", 32'(cmdReady), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("len0_done_pulse", 32'(pktDone), 32'd0);
    chk("len0_valid2", 32'(dataOutValid), 32'd0);

    // Oversized length is clamped to MAX_LEN beats.
    send_cmd(32'd0, 32'd3, LW'(MAX_LEN + 5));
    expect_pkt("clamp", 32'd0, 32'd3, MAX_LEN, 0);

    // Reset between edges during beat 3 of an 8-beat packet.
    send_cmd(32'h100, 32'd1, LW'(8));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_data", dataOut, 32'h100 + 32'(i));
    end
    @(negedge clk);
    chk("abort_beat3", dataOut, 32'h103);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid", 32'(dataOutValid), 32'd0);
    chk("abort_data0", dataOut, 32'd0);
    chk("abort_last", 32'(dataOutLast), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmdReady), 32'd1);
    chk("abort_done", 32'(pktDone), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(pktDone), 32'd0);
      chk("abort_no_valid", 32'(dataOutValid), 32'd0);
    end
    send_cmd(32'h20, 32'd3, LW'(2));
    expect_pkt("fresh", 32'h20, 32'd3, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_pkt_source.md
STREAM_PKT_SOURCE -- requirements
Module: stream_pkt_source

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data beat width in bits.
REQ-002 The block SHALL have parameter MAX_LEN, default 256, giving the maximum beats per packet; LEN_W = clog2(MAX_LEN+1).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port cmdStart  input  DATA_WIDTH  the value of the first beat.
REQ-006 The block SHALL have port cmdStep  input  DATA_WIDTH  the increment between consecutive beats.
REQ-007 The block SHALL have port cmdLen  input  LEN_W  the number of beats in the packet.
REQ-008 The block SHALL have port cmdValid  input  1  the command offer.
REQ-009 The block SHALL have port cmdReady  output  1  the command accept.
REQ-010 The block SHALL have port dataOut  output  DATA_WIDTH  the stream beat data.
REQ-011 The block SHALL have port dataOutValid  output  1  the stream beat valid.
REQ-012 The block SHALL have port dataOutReady  input  1  downstream ready.
REQ-013 The block SHALL have port dataOutLast  output  1  which marks the final beat of a packet.
REQ-014 The block SHALL have port busy  output  1  which is high while a packet is in progress.
REQ-015 The block SHALL have port pktDone  output  1  a one-cycle pulse after the last beat handshake.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-017 cmdReady SHALL equal (state == IDLE), registered-state only, with no combinational path from any input.
REQ-018 A command handshake SHALL complete when cmdValid and cmdReady are both high at a rising edge.
REQ-019 On a command handshake with cmdLen >= 1, the block SHALL latch cmdStart and cmdStep, latch the beat count min(cmdLen, MAX_LEN), and enter SEND.
REQ-020 On a command handshake with cmdLen == 0, the block SHALL stay in IDLE, emit no beats, and pulse pktDone on the next cycle.
REQ-021 The first beat SHALL be presented with dataOutValid high in the cycle after the command handshake (latency 1).
REQ-022 Beat i, counting from 0, SHALL carry cmdStart + i*cmdStep modulo 2^DATA_WIDTH, computed as a running registered sum so wrap-around is silent.
REQ-023 Once dataOutValid is high, dataOut, dataOutLast and dataOutValid SHALL hold stable until a beat handshake (dataOutValid && dataOutReady) occurs.
REQ-024 dataOutValid SHALL NOT depend combinationally on dataOutReady.
REQ-025 In SEND, dataOutValid SHALL be continuously high, giving full throughput of one beat per cycle when dataOutReady is held high.
REQ-026 dataOutLast SHALL be high exactly on the beat whose remaining-count is 1.
REQ-027 The handshake of the last beat SHALL return the FSM to IDLE and pulse pktDone in the following cycle.
REQ-028 There SHALL be a minimum one-cycle gap (dataOutValid low) between consecutive packets.
REQ-029 busy SHALL be high in SEND and low in IDLE.
REQ-030 cmdValid, cmdStart, cmdStep and cmdLen SHALL be ignored while in SEND.

Reset
REQ-031 Reset assertion SHALL, asynchronously and even mid-packet, force state IDLE, dataOutValid 0, dataOutLast 0, dataOut 0, busy 0, pktDone 0, and all internal counters 0.
REQ-032 cmdReady SHALL read 1 during reset.
REQ-033 A packet interrupted by reset SHALL be abandoned, with no resume and no pktDone.
REQ-034 The first command SHALL be acceptable on the first rising edge after reset deassertion.

Structure
REQ-035 A shared package stream_pkg SHALL hold the state enum {IDLE, SEND} and a LEN_W helper function.
REQ-036 The remaining-beat down-counter, with its load, decrement and isLast flag, SHALL be a sub-module stream_beat_counter, parameterised by MAX_LEN.
REQ-037 The top level SHALL contain the FSM, the data accumulator and the output registers.

Verification
REQ-038 Directed test: start=0x10, step=4, len=3, ready held high -> beats 0x10, 0x14, 0x18 on consecutive cycles, last on 0x18, pktDone one cycle later.
REQ-039 Directed test: start=0xFFFFFFFE, step=1, len=4 -> beats 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (wrap-around).
REQ-040 Directed test: len=2 with dataOutReady low for 5 cycles on beat 0 -> dataOut and valid stable for all 5 cycles, then 2 beats delivered.
REQ-041 Directed test: len=0 -> no dataOutValid, pktDone pulses once, cmdReady stays 1.
REQ-042 Directed test: len=MAX_LEN+5 -> exactly MAX_LEN beats, last on beat MAX_LEN-1.
REQ-043 Directed test: reset asserted between clock edges on beat 3 of len=8 -> outputs cleared immediately, no pktDone, next command produces a correct fresh packet.
